bubble_host_reader: RTL and testbench

- Synthesizable host-side counterpart of the BubbleDrive8 emulator: plays the bubble memory controller role.
- Drives the drive's nBSEN and nREPEN strobes with programmable timing.
- Samples the emulator's DOUT0/DOUT1 serial outputs and packs them into bytes for a checker or logic analyser.
- Used on-board for self-test and in benches as the initiator the drive responds to.

---
 rtl/bubble_host_reader_if.sv | 27 ++
 rtl/bubble_host_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_bubble_host_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bubble_host_reader_if.sv
// Host-side bundle between the bubble reader, its requester and the drive's
// serial outputs. The slave modport is the reader itself.
interface bubble_host_reader_if;
  logic       start;
  logic [7:0] page_count;
  logic       abort;
  logic       DIN0;
  logic       DIN1;
  logic       nBSEN;
  logic       nREPEN;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] page_idx;

  modport master (
    output start, page_count, abort, DIN0, DIN1,
    input  nBSEN, nREPEN, busy, done, aborted, byte_data, byte_valid, page_idx
  );

  modport slave (
    input  start, page_count, abort, DIN0, DIN1,
    output nBSEN, nREPEN, busy, done, aborted, byte_data, byte_valid, page_idx
  );
endinterface

// File: rtl/bubble_host_reader.sv
// Bubble memory controller stand-in: strobes nBSEN/nREPEN with programmable
// timing and packs the drive's DOUT0/DOUT1 samples into bytes.
//
// state  | meaning
// IDLE   | waiting for start
// SPINUP | nBSEN low, counting down to the first replicate pulse
// REP    | nREPEN low for the replicate pulse
// OFS    | nREPEN released, waiting for the first sample point
// SAMPLE | capturing 2 bits every bit period
// GAP    | waiting for the page period to expire
// STOP   | nBSEN held low before release
module bubble_host_reader #(
  parameter int SPINUP_CYC       = 25000,
  parameter int REP_PULSE_CYC    = 343,
  parameter int REP_PERIOD_CYC   = 960,
  parameter int SAMPLE_OFS_CYC   = 40,
  parameter int BIT_PERIOD_CYC   = 4,
  parameter int SAMPLES_PER_PAGE = 128,
  parameter int STOP_CYC         = 211
) (
  input  logic                  MCLK,
  input  logic                  nMRST,
  bubble_host_reader_if.slave   bus
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(max2(SPINUP_CYC, REP_PULSE_CYC),
                                     max2(SAMPLE_OFS_CYC, BIT_PERIOD_CYC)), STOP_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PW = $clog2(REP_PERIOD_CYC + 1);
  localparam int SW = $clog2(SAMPLES_PER_PAGE + 1);

  localparam logic [CW-1:0] C_SPIN  = CW'(SPINUP_CYC - 1);
  localparam logic [CW-1:0] C_PULSE = CW'(REP_PULSE_CYC - 1);
  localparam logic [CW-1:0] C_OFS   = CW'(SAMPLE_OFS_CYC - 1);
  localparam logic [CW-1:0] C_BIT   = CW'(BIT_PERIOD_CYC - 1);
  localparam logic [CW-1:0] C_STOP  = CW'(STOP_CYC - 1);
  localparam logic [PW-1:0] C_PER   = PW'(REP_PERIOD_CYC - 1);
  localparam logic [SW-1:0] C_LAST  = SW'(SAMPLES_PER_PAGE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPINUP, S_REP, S_OFS, S_SAMPLE, S_GAP, S_STOP
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [PW-1:0]   r_per, w_per_nx;
  logic [SW-1:0]   r_smp, w_smp_nx;
  logic [7:0]      r_left, w_left_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic            r_nbsen, w_nbsen_nx;
  logic            r_nrepen, w_nrepen_nx;
  logic            r_busy, w_busy_nx;
  logic            r_done, w_done_nx;
  logic            r_aborted, w_aborted_nx;
  logic [7:0]      r_byte_data, w_byte_nx;
  logic            r_byte_valid, w_bvalid_nx;
  logic [7:0]      r_page_idx, w_pidx_nx;
  logic [1:0]      r_din_s1, r_din_s2;
  logic [1:0]      w_k;

  assign w_k = r_smp[1:0];

  always_ff @(posedge MCLK or negedge nMRST) begin
    if (!nMRST) begin
      r_din_s1 <= '0;
      r_din_s2 <= '0;
    end else begin
      r_din_s1 <= {bus.DIN1, bus.DIN0};
      r_din_s2 <= r_din_s1;
    end
  end

  always_ff @(posedge MCLK or negedge nMRST) begin
    if (!nMRST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_per        <= '0;
      r_smp        <= '0;
      r_left       <= '0;
      r_shift      <= '0;
      r_nbsen      <= 1'b1;
      r_nrepen     <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_page_idx   <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_per        <= w_per_nx;
      r_smp        <= w_smp_nx;
      r_left       <= w_left_nx;
      r_shift      <= w_shift_nx;
      r_nbsen      <= w_nbsen_nx;
      r_nrepen     <= w_nrepen_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_aborted    <= w_aborted_nx;
      r_byte_data  <= w_byte_nx;
      r_byte_valid <= w_bvalid_nx;
      r_page_idx   <= w_pidx_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    // The period counter free-runs down from each nREPEN fall and parks at zero.
    w_per_nx     = (r_per != '0) ? r_per - 1'b1 : r_per;
    w_smp_nx     = r_smp;
    w_left_nx    = r_left;
    w_shift_nx   = r_shift;
    w_nbsen_nx   = r_nbsen;
    w_nrepen_nx  = r_nrepen;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_aborted_nx = 1'b0;
    w_byte_nx    = r_byte_data;
    w_bvalid_nx  = 1'b0;
    w_pidx_nx    = r_page_idx;

    if (r_state != S_IDLE && bus.abort) begin
      w_state_nx   = S_IDLE;
      w_nbsen_nx   = 1'b1;
      w_nrepen_nx  = 1'b1;
      w_busy_nx    = 1'b0;
      w_aborted_nx = 1'b1;
      w_pidx_nx    = '0;
      w_cnt_nx     = '0;
      w_per_nx     = '0;
      w_smp_nx     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.page_count != 8'd0) begin
              w_left_nx  = bus.page_count - 8'd1;
              w_nbsen_nx = 1'b0;
              w_busy_nx  = 1'b1;
              w_cnt_nx   = C_SPIN;
              w_state_nx = S_SPINUP;
            end else begin
              w_done_nx = 1'b1;
            end
          end
        end
        S_SPINUP: begin
          if (r_cnt == '0) begin
            w_nrepen_nx = 1'b0;
            w_cnt_nx    = C_PULSE;
            w_per_nx    = C_PER;
            w_state_nx  = S_REP;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        S_REP: begin
          if (r_cnt == '0) begin
            w_nrepen_nx = 1'b1;
            w_cnt_nx    = C_OFS;
            w_state_nx  = S_OFS;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        S_OFS: begin
          if (r_cnt == '0) begin
            w_smp_nx   = '0;
            w_state_nx = S_SAMPLE;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (r_cnt == '0) begin
            case (w_k)
              2'd0:    w_shift_nx[7:6] = r_din_s2;
              2'd1:    w_shift_nx[5:4] = r_din_s2;
              2'd2:    w_shift_nx[3:2] = r_din_s2;
              default: begin
                w_shift_nx[1:0] = r_din_s2;
                w_byte_nx       = {r_shift[7:2], r_din_s2};
                w_bvalid_nx     = 1'b1;
              end
            endcase
            w_smp_nx = r_smp + 1'b1;
            w_cnt_nx = C_BIT;
            if (r_smp == C_LAST) begin
              w_state_nx = S_GAP;
            end
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_per == '0) begin
            if (r_left != 8'd0) begin
              w_left_nx   = r_left - 8'd1;
              w_pidx_nx   = r_page_idx + 8'd1;
              w_nrepen_nx = 1'b0;
              w_cnt_nx    = C_PULSE;
              w_per_nx    = C_PER;
              w_state_nx  = S_REP;
            end else begin
              w_cnt_nx   = C_STOP;
              w_state_nx = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (r_cnt == '0) begin
            w_nbsen_nx = 1'b1;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_pidx_nx  = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign bus.nBSEN      = r_nbsen;
  assign bus.nREPEN     = r_nrepen;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.aborted    = r_aborted;
  assign bus.byte_data  = r_byte_data;
  assign bus.byte_valid = r_byte_valid;
  assign bus.page_idx   = r_page_idx;

endmodule

// File: tb/tb_bubble_host_reader.sv
// Bench for bubble_host_reader: strobe timing, byte packing against a queue of
// expected bytes, zero-page start, abort and asynchronous reset.
module tb_bubble_host_reader;
  localparam int SPIN = 2000;
  localparam int PULSE = 343;
  localparam int PERIOD = 960;
  localparam int OFS = 40;
  localparam int BITP = 4;
  localparam int SPP = 128;
  localparam int STOPC = 211;
  localparam int BPP = SPP / 4;
  localparam int LIM = 8000;

  logic MCLK = 1'b0;
  logic nMRST = 1'b0;
  bubble_host_reader_if bus();

  bubble_host_reader #(
    .SPINUP_CYC(SPIN), .REP_PULSE_CYC(PULSE), .REP_PERIOD_CYC(PERIOD),
    .SAMPLE_OFS_CYC(OFS), .BIT_PERIOD_CYC(BITP), .SAMPLES_PER_PAGE(SPP),
    .STOP_CYC(STOPC)
  ) dut (
    .MCLK(MCLK), .nMRST(nMRST), .bus(bus.slave)
  );

  always #5 MCLK = ~MCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int fall_q[$];
  int rise_q[$];
  logic [7:0] pidx_q[$];
  int t_bsen_fall = -1;
  int t_done = -1;
  int n_done = 0, n_abort = 0, n_busy = 0, n_bsen_low = 0, n_bytes = 0;
  logic p_nbsen = 1'b1, p_nrepen = 1'b1;

  // Monitor and scoreboard: every byte_valid pops one expected byte.
  always @(negedge MCLK) begin
    logic [7:0] e;
    if (p_nbsen && !bus.nBSEN) t_bsen_fall = cyc;
    if (p_nrepen && !bus.nREPEN) begin
      fall_q.push_back(cyc);
      pidx_q.push_back(bus.page_idx);
    end
    if (!p_nrepen && bus.nREPEN) rise_q.push_back(cyc);
    if (bus.done) begin n_done++; t_done = cyc; end
    if (bus.aborted) n_abort++;
    if (bus.busy) n_busy++;
    if (!bus.nBSEN) n_bsen_low++;
    if (bus.byte_valid) begin
      n_bytes++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL byte_unexpected: got %02h, required none", bus.byte_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.byte_data !== e) begin
          n_bad++;
          $display("FAIL byte_data: got %02h, required %02h", bus.byte_data, e);
        end
      end
    end
    p_nbsen = bus.nBSEN;
    p_nrepen = bus.nREPEN;
  end

  task automatic tick(int n);
    repeat (n) begin @(negedge MCLK); #1; end
  endtask

  task automatic clear_mon();
    exp_q.delete(); fall_q.delete(); rise_q.delete(); pidx_q.delete();
    t_bsen_fall = -1; t_done = -1;
    n_done = 0; n_abort = 0; n_busy = 0; n_bsen_low = 0; n_bytes = 0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.page_count = 8'd0; bus.abort = 1'b0;
    bus.DIN0 = 1'b0; bus.DIN1 = 1'b0;
    nMRST = 1'b0;
    tick(3);
    n_cmp += 8;
    if (bus.nBSEN !== 1'b1) begin n_bad++; $display("FAIL rst_nBSEN: got %b, required 1", bus.nBSEN); end
    if (bus.nREPEN !== 1'b1) begin n_bad++; $display("FAIL rst_nREPEN: got %b, required 1", bus.nREPEN); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b, required 0", bus.done); end
    if (bus.aborted !== 1'b0) begin n_bad++; $display("FAIL rst_aborted: got %b, required 0", bus.aborted); end
    if (bus.byte_data !== 8'h00) begin n_bad++; $display("FAIL rst_byte_data: got %02h, required 00", bus.byte_data); end
    if (bus.byte_valid !== 1'b0) begin n_bad++; $display("FAIL rst_byte_valid: got %b, required 0", bus.byte_valid); end
    if (bus.page_idx !== 8'h00) begin n_bad++; $display("FAIL rst_page_idx: got %0d, required 0", bus.page_idx); end
    nMRST = 1'b1;
    tick(2);
  endtask

  task automatic test_single_page();
    int t_start, g;
    clear_mon();
    bus.DIN1 = 1'b1; bus.DIN0 = 1'b0;
    for (int b = 0; b < BPP; b++) exp_q.push_back(8'hAA);
    t_start = cyc;
    bus.start = 1'b1; bus.page_count = 8'd1;
    tick(1);
    bus.start = 1'b0;
    tick(20);
    // a start while busy must not retrigger or change the page count
    bus.start = 1'b1; bus.page_count = 8'd7;
    tick(1);
    bus.start = 1'b0;
    g = 0;
    while (n_done == 0 && g < LIM) begin tick(1); g++; end
    if (g >= LIM) begin n_cmp++; n_bad++; $display("FAIL single_done_timeout: got no done, required done"); end
    tick(5);
    n_cmp += 9;
    if (t_bsen_fall !== t_start + 1) begin n_bad++; $display("FAIL single_nbsen_fall: got %0d, required %0d", t_bsen_fall, t_start + 1); end
    if (fall_q.size() !== 1) begin n_bad++; $display("FAIL single_rep_count: got %0d, required 1", fall_q.size()); end
    if (fall_q.size() > 0 && fall_q[0] - t_bsen_fall !== SPIN) begin n_bad++; $display("FAIL single_spinup: got %0d, required %0d", fall_q[0] - t_bsen_fall, SPIN); end
    if (fall_q.size() > 0 && rise_q.size() > 0 && rise_q[0] - fall_q[0] !== PULSE) begin n_bad++; $display("FAIL single_pulse: got %0d, required %0d", rise_q[0] - fall_q[0], PULSE); end
    if (n_bytes !== BPP) begin n_bad++; $display("FAIL single_bytes: got %0d, required %0d", n_bytes, BPP); end
    if (n_done !== 1) begin n_bad++; $display("FAIL single_done_count: got %0d, required 1", n_done); end
    if (fall_q.size() > 0 && t_done - fall_q[0] !== PERIOD + STOPC) begin n_bad++; $display("FAIL single_done_time: got %0d, required %0d", t_done - fall_q[0], PERIOD + STOPC); end
    if (n_busy !== t_done - t_bsen_fall) begin n_bad++; $display("FAIL single_busy_len: got %0d, required %0d", n_busy, t_done - t_bsen_fall); end
    if (n_bsen_low !== t_done - t_bsen_fall) begin n_bad++; $display("FAIL single_nbsen_len: got %0d, required %0d", n_bsen_low, t_done - t_bsen_fall); end
  endtask

  task automatic test_three_pages();
    int g;
    logic [1:0] v;
    clear_mon();
    bus.DIN1 = 1'b0; bus.DIN0 = 1'b0;
    bus.start = 1'b1; bus.page_count = 8'd3;
    tick(1);
    bus.start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < BPP; b++) exp_q.push_back(8'h1B);
      g = 0;
      while (bus.nREPEN !== 1'b0 && g < LIM) begin tick(1); g++; end
      while (bus.nREPEN !== 1'b1 && g < LIM) begin tick(1); g++; end
      if (g >= LIM) begin n_cmp++; n_bad++; $display("FAIL multi_rep_timeout: page %0d got no pulse, required pulse", p); end
      // each value is held across its sample point, clear of the synchronizer latency
      tick(OFS - 3);
      for (int m = 0; m < SPP; m++) begin
        v = m[1:0];
        bus.DIN1 = v[1]; bus.DIN0 = v[0];
        tick(BITP);
      end
    end
    g = 0;
    while (n_done == 0 && g < LIM) begin tick(1); g++; end
    if (g >= LIM) begin n_cmp++; n_bad++; $display("FAIL multi_done_timeout: got no done, required done"); end
    tick(2);
    n_cmp += 5;
    if (fall_q.size() !== 3) begin n_bad++; $display("FAIL multi_rep_count: got %0d, required 3", fall_q.size()); end
    for (int i = 1; i < fall_q.size(); i++) begin
      n_cmp++;
      if (fall_q[i] - fall_q[i-1] !== PERIOD) begin n_bad++; $display("FAIL multi_period: got %0d, required %0d", fall_q[i] - fall_q[i-1], PERIOD); end
    end
    for (int i = 0; i < pidx_q.size(); i++) begin
      n_cmp++;
      if (pidx_q[i] !== 8'(i)) begin n_bad++; $display("FAIL multi_page_idx: got %0d, required %0d", pidx_q[i], i); end
    end
    if (n_bytes !== 3 * BPP) begin n_bad++; $display("FAIL multi_bytes: got %0d, required %0d", n_bytes, 3 * BPP); end
    if (exp_q.size() !== 0) begin n_bad++; $display("FAIL multi_leftover: got %0d, required 0", exp_q.size()); end
    if (fall_q.size() == 3 && t_done - fall_q[2] !== PERIOD + STOPC) begin n_bad++; $display("FAIL multi_done_time: got %0d, required %0d", t_done - fall_q[2], PERIOD + STOPC); end
    if (bus.page_idx !== 8'd0) begin n_bad++; $display("FAIL multi_idx_after: got %0d, required 0", bus.page_idx); end
  endtask

  task automatic test_zero_pages();
    int t_start;
    clear_mon();
    t_start = cyc;
    bus.start = 1'b1; bus.page_count = 8'd0;
    tick(1);
    bus.start = 1'b0;
    tick(20);
    n_cmp += 5;
    if (n_done !== 1) begin n_bad++; $display("FAIL zero_done_count: got %0d, required 1", n_done); end
    if (t_done !== t_start + 1) begin n_bad++; $display("FAIL zero_done_time: got %0d, required %0d", t_done, t_start + 1); end
    if (n_busy !== 0) begin n_bad++; $display("FAIL zero_busy: got %0d, required 0", n_busy); end
    if (n_bsen_low !== 0) begin n_bad++; $display("FAIL zero_nbsen: got %0d, required 0", n_bsen_low); end
    if (fall_q.size() !== 0 || n_bytes !== 0) begin n_bad++; $display("FAIL zero_activity: got %0d pulses %0d bytes, required 0", fall_q.size(), n_bytes); end
  endtask

  task automatic test_abort_restart();
    int g, t_start;
    clear_mon();
    bus.DIN1 = 1'b0; bus.DIN0 = 1'b1;
    bus.abort = 1'b1;
    tick(2);
    bus.abort = 1'b0;
    bus.start = 1'b1; bus.page_count = 8'd1;
    tick(1);
    bus.start = 1'b0;
    g = 0;
    while (bus.nREPEN !== 1'b0 && g < LIM) begin tick(1); g++; end
    while (bus.nREPEN !== 1'b1 && g < LIM) begin tick(1); g++; end
    if (g >= LIM) begin n_cmp++; n_bad++; $display("FAIL abort_rep_timeout: got no pulse, required pulse"); end
    tick(OFS + 5);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    n_cmp += 5;
    if (bus.nBSEN !== 1'b1) begin n_bad++; $display("FAIL abort_nBSEN: got %b, required 1", bus.nBSEN); end
    if (bus.nREPEN !== 1'b1) begin n_bad++; $display("FAIL abort_nREPEN: got %b, required 1", bus.nREPEN); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b, required 0", bus.busy); end
    if (bus.aborted !== 1'b1) begin n_bad++; $display("FAIL abort_pulse: got %b, required 1", bus.aborted); end
    if (n_abort !== 1) begin n_bad++; $display("FAIL abort_idle_ignored: got %0d pulses, required 1", n_abort); end
    tick(1);
    n_cmp++;
    if (bus.aborted !== 1'b0) begin n_bad++; $display("FAIL abort_pulse_len: got %b, required 0", bus.aborted); end
    tick(40);
    n_cmp++;
    if (n_bytes !== 0 || n_done !== 0) begin n_bad++; $display("FAIL abort_quiet: got %0d bytes %0d done, required 0", n_bytes, n_done); end
    // restart with start and abort together: start has priority in IDLE
    clear_mon();
    for (int b = 0; b < BPP; b++) exp_q.push_back(8'h55);
    t_start = cyc;
    bus.start = 1'b1; bus.abort = 1'b1; bus.page_count = 8'd1;
    tick(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    g = 0;
    while (n_done == 0 && g < LIM) begin tick(1); g++; end
    if (g >= LIM) begin n_cmp++; n_bad++; $display("FAIL restart_done_timeout: got no done, required done"); end
    tick(2);
    n_cmp += 4;
    if (t_bsen_fall !== t_start + 1) begin n_bad++; $display("FAIL restart_nbsen_fall: got %0d, required %0d", t_bsen_fall, t_start + 1); end
    if (n_abort !== 0) begin n_bad++; $display("FAIL restart_aborted: got %0d, required 0", n_abort); end
    if (n_bytes !== BPP) begin n_bad++; $display("FAIL restart_bytes: got %0d, required %0d", n_bytes, BPP); end
    if (n_done !== 1) begin n_bad++; $display("FAIL restart_done: got %0d, required 1", n_done); end
  endtask

  task automatic test_async_reset();
    int g, t_start;
    clear_mon();
    bus.start = 1'b1; bus.page_count = 8'd2;
    tick(1);
    bus.start = 1'b0;
    g = 0;
    while (bus.nREPEN !== 1'b0 && g < LIM) begin tick(1); g++; end
    if (g >= LIM) begin n_cmp++; n_bad++; $display("FAIL areset_rep_timeout: got no pulse, required pulse"); end
    tick(10);
    nMRST = 1'b0;
    #1;
    n_cmp += 3;
    if (bus.nREPEN !== 1'b1) begin n_bad++; $display("FAIL areset_nREPEN: got %b, required 1", bus.nREPEN); end
    if (bus.nBSEN !== 1'b1) begin n_bad++; $display("FAIL areset_nBSEN: got %b, required 1", bus.nBSEN); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b, required 0", bus.busy); end
    tick(3);
    nMRST = 1'b1;
    tick(1);
    clear_mon();
    tick(50);
    n_cmp++;
    if (n_bsen_low !== 0 || n_busy !== 0) begin n_bad++; $display("FAIL areset_idle: got %0d low %0d busy, required 0", n_bsen_low, n_busy); end
    // only IDLE answers a zero-page start with done on the next cycle
    t_start = cyc;
    bus.start = 1'b1; bus.page_count = 8'd0;
    tick(1);
    bus.start = 1'b0;
    tick(3);
    n_cmp++;
    if (t_done !== t_start + 1) begin n_bad++; $display("FAIL areset_fsm_idle: got done at %0d, required %0d", t_done, t_start + 1); end
  endtask

  initial begin
    test_reset();
    test_single_page();
    test_three_pages();
    test_zero_pages();
    test_abort_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
